// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit command issuer.
//   - Op codes understood by the 8-bit combinational logic unit.
//   - Issuer FSM state encoding.
//   - Packed command record stored in the command FIFO (18 bits).
//   - Helper that selects the b operand actually driven to the unit.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NOTA = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int CMD_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } issuer_state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  // NOT a ignores b; drive a fixed zero so lu_b carries no stale operand.
  function automatic logic [7:0] drive_b(input cmd_t c);
    logic [7:0] r;
    if (c.op == OP_NOTA) begin
      r = 8'h00;
    end else begin
      r = c.b;
    end
    return r;
  endfunction

endpackage

// File: rtl/logic_cmd_fifo.sv
// Command FIFO for the logic-unit issuer.
//   DEPTH x cmd_t storage, pointers carry an extra wrap bit to tell full from empty.
// Ports:
//   clk, rst_n  clock, async active-low reset (empties the FIFO)
//   push        write request; ignored while full
//   pop         read request; ignored while empty
//   wr_data     command written on push
//   rd_data     head command (valid while !empty)
//   full/empty  occupancy flags
module logic_cmd_fifo
  import logic_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wr_data,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle keep occupancy constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage write; contents are don't-care until pointed at by a push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/logic_cmd_issuer.sv
// Initiator for the 8-bit combinational logic unit.
//   Queues commands, drives lu_a/lu_b/lu_ctrl from registers, waits SETTLE cycles,
//   captures lu_s and offers it on a valid/ready result channel, in command order.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b           command payload
//   lu_a, lu_b, lu_ctrl            registered drive to the logic unit
//   lu_s                           logic unit result
//   res_valid/res_ready            result handshake
//   res_data, res_op               captured result and the op that produced it
//   busy                           work pending or in flight
//   ops_done                       results handed off, wrapping counter
module logic_cmd_issuer
  import logic_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       lu_a,
  output logic [7:0]       lu_b,
  output logic [1:0]       lu_ctrl,
  input  logic [7:0]       lu_s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [1:0]       res_op,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int            SW       = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);

  issuer_state_t state;
  issuer_state_t next_state;
  logic [SW-1:0] cnt;
  cmd_t          push_cmd;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          load;
  logic          capture;
  logic          handoff;

  assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};

  logic_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid),
    .pop     (load),
    .wr_data (push_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_ONE) begin
          next_state = HOLD;
        end else begin
          next_state = WAIT;
        end
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          if (!fifo_empty) begin
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM control strobes: load pops the head into lu_*, capture samples lu_s,
  // handoff retires the presented result.
  always_comb begin
    load    = 1'b0;
    capture = 1'b0;
    handoff = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
      WAIT: begin
        if (cnt == CNT_ONE) begin
          capture = 1'b1;
        end else begin
          capture = 1'b0;
        end
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          handoff = 1'b1;
          load    = !fifo_empty;
        end else begin
          handoff = 1'b0;
        end
      end
      default: begin
        load    = 1'b0;
        capture = 1'b0;
        handoff = 1'b0;
      end
    endcase
  end

  // Logic-unit drive registers and settle counter; lu_* keep their value between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_a    <= 8'h00;
      lu_b    <= 8'h00;
      lu_ctrl <= 2'b00;
      cnt     <= {SW{1'b0}};
    end else begin
      if (load) begin
        lu_a    <= head.a;
        lu_b    <= drive_b(head);
        lu_ctrl <= head.op;
        cnt     <= SETTLE_V;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Result registers; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_op    <= 2'b00;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= lu_s;
        res_op    <= lu_ctrl;
      end else if (handoff) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Handed-off result counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= {CNT_W{1'b0}};
    end else begin
      if (handoff) begin
        ops_done <= ops_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_cmd_issuer.sv
// Self-checking bench for logic_cmd_issuer with a behavioural logic unit on lu_*/lu_s.
// Stimulus pushes hand-computed expected results into a scoreboard; a negedge monitor
// pops and compares on every result handshake.
module tb_logic_cmd_issuer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [7:0]       cmd_a = 8'h00;
  logic [7:0]       cmd_b = 8'h00;
  logic [7:0]       lu_a;
  logic [7:0]       lu_b;
  logic [1:0]       lu_ctrl;
  logic [7:0]       lu_s;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_data;
  logic [1:0]       res_op;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [1:0] prev_op = 2'b00;
  exp_t       mon_e;

  logic_cmd_issuer #(
    .DEPTH  (4),
    .SETTLE (1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_ctrl   (lu_ctrl),
    .lu_s      (lu_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // Combinational logic unit.
  function automatic logic [7:0] lu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
    case (c)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return ~(a & b);
    endcase
  endfunction

  assign lu_s = lu_fn(lu_a, lu_b, lu_ctrl);

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests = n_tests + 1;
    n_fail  = n_fail + 1;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: result ordering/values, stability under stall, NOT-a drives lu_b=0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && res_valid) begin
        check("hold_data", {24'h0, res_data}, {24'h0, prev_data});
        check("hold_op", {30'h0, res_op}, {30'h0, prev_op});
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_tests = n_tests + 1;
          n_fail  = n_fail + 1;
          $display("FAIL unexpected_result: got data %0h op %0h, expected none", res_data, res_op);
        end else begin
          mon_e = sb.pop_front();
          check("res_data", {24'h0, res_data}, {24'h0, mon_e.data});
          check("res_op", {30'h0, res_op}, {30'h0, mon_e.op});
          if (mon_e.op == 2'b10) begin
            check("nota_lu_b", {24'h0, lu_b}, 32'h0);
          end
        end
        hs_cyc.push_back(cyc);
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      prev_op   = res_op;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Offer one command, hold it until accepted; called just after a rising edge.
  task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        sb.push_back('{op: op, data: exp});
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) fail_now("push_accept");
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && !res_valid) done = 1'b1;
    end
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_sb_empty"}, sb.size(), 32'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    check({name, "_res_valid"}, {31'h0, res_valid}, 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_lu_a"}, {24'h0, lu_a}, 32'h0);
    check({name, "_lu_b"}, {24'h0, lu_b}, 32'h0);
    check({name, "_lu_ctrl"}, {30'h0, lu_ctrl}, 32'h0);
    check({name, "_res_data"}, {24'h0, res_data}, 32'h0);
    check({name, "_res_op"}, {30'h0, res_op}, 32'h0);
    check({name, "_ops_done"}, {28'h0, ops_done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single op, latency and count
    push(2'b00, 8'hF0, 8'h3C, 8'h30);
    @(negedge clk);
    @(negedge clk);
    check("t1_not_yet_valid", {31'h0, res_valid}, 32'h0);
    @(negedge clk);
    check("t1_valid_2_after", {31'h0, res_valid}, 32'h1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain("t1");
    check("t1_ops_done", {28'h0, ops_done}, 32'd1);

    // 2: four ops back-to-back, one result per two cycles
    hs_cyc.delete();
    @(posedge clk);
    #1;
    push(2'b00, 8'hF0, 8'h3C, 8'h30);
    push(2'b01, 8'hF0, 8'h3C, 8'hFC);
    push(2'b10, 8'hF0, 8'h3C, 8'h0F);
    push(2'b11, 8'hF0, 8'h3C, 8'hCF);
    wait_drain("t2");
    check("t2_results", hs_cyc.size(), 32'd4);
    for (int i = 1; i < 4 && i < hs_cyc.size(); i++) begin
      check("t2_spacing", hs_cyc[i] - hs_cyc[i-1], 32'd2);
    end
    check("t2_ops_done", {28'h0, ops_done}, 32'd5);

    // 3: backpressure, FIFO fills and a further command is held
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    push(2'b00, 8'hAA, 8'h0F, 8'h0A);
    push(2'b01, 8'hA0, 8'h05, 8'hA5);
    push(2'b10, 8'h55, 8'h77, 8'hAA);
    push(2'b11, 8'hFF, 8'h0F, 8'hF0);
    push(2'b00, 8'h3C, 8'h3C, 8'h3C);
    @(negedge clk);
    check("t3_full", {31'h0, cmd_ready}, 32'h0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 8'h00;
    cmd_b     = 8'h81;
    repeat (3) begin
      @(negedge clk);
      check("t3_held", {31'h0, cmd_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    push(2'b01, 8'h00, 8'h81, 8'h81);
    wait_drain("t3");
    check("t3_ops_done", {28'h0, ops_done}, 32'd11);

    // 4: reset while WAIT with two commands queued
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    push(2'b00, 8'h0F, 8'hFF, 8'h0F);
    push(2'b01, 8'h0F, 8'hF0, 8'hFF);
    push(2'b11, 8'h00, 8'h00, 8'hFF);
    push(2'b10, 8'h12, 8'h34, 8'hED);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("t4_valid_drop", {31'h0, res_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t4_no_stale", {31'h0, res_valid}, 32'h0);
    end
    check_reset_outputs("t4");

    // 5: counter wrap at CNT_W=4 after 17 results
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(2'b00, 8'(i), 8'hFF, 8'(i));
    end
    wait_drain("t5");
    check("t5_wrap", {28'h0, ops_done}, 32'd1);

    // 6: push and pop on the same edge at occupancy 2
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    push(2'b01, 8'h11, 8'h22, 8'h33);
    push(2'b00, 8'hF0, 8'h0F, 8'h00);
    push(2'b11, 8'hF0, 8'hF0, 8'h0F);
    res_ready = 1'b1;
    push(2'b10, 8'hC3, 8'h5A, 8'h3C);
    res_ready = 1'b0;
    push(2'b00, 8'hFF, 8'h81, 8'h81);
    @(negedge clk);
    check("t6_occ3_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    push(2'b01, 8'h40, 8'h02, 8'h42);
    @(negedge clk);
    check("t6_occ4_full", {31'h0, cmd_ready}, 32'h0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain("t6");
    check("t6_ops_done", {28'h0, ops_done}, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
